// File: rtl/button_step_controller_pkg.sv
// Shared state codes for the button step controller and its debug port.
// The state_dbg output exposes these encodings directly.
package button_step_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_HELD    = 3'd2,
    ST_REPEAT  = 3'd3,
    ST_RELEASE = 3'd4
  } state_e;

  // Debounced level is asserted once a press has been accepted until the release is confirmed.
  function automatic logic state_is_pressed(input state_e s);
    return (s == ST_HELD) || (s == ST_REPEAT) || (s == ST_RELEASE);
  endfunction

endpackage

// File: rtl/button_step_controller_sync_2ff.sv
// Two-flop synchroniser for an asynchronous level input; two-cycle latency.
// Shared by every button pin, async active-high reset clears both stages to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/button_step_controller.sv
// Debounces a raw push-button into one-cycle step pulses with optional auto-repeat.
// First step appears DEBOUNCE_CYCLES+2 edges after the press is first sampled.
module button_step_controller
  import button_step_controller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 10,
  parameter int REPEAT_PERIOD   = 3,
  parameter int TIMER_W         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic       repeat_en,
  output logic       step,
  output logic       btn_level,
  output logic [2:0] state_dbg
);

  localparam logic [TIMER_W-1:0] DEB_LAST = TIMER_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] RD_LAST  = TIMER_W'(REPEAT_DELAY - 1);
  localparam logic [TIMER_W-1:0] RP_LAST  = TIMER_W'(REPEAT_PERIOD - 1);

  logic               btn_sync;
  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               step_q, step_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (reset),
    .d   (btn_raw),
    .q   (btn_sync)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TIMER_W'(1);
    step_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (btn_sync) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (!btn_sync) begin
          state_d = ST_IDLE;
        end else if (timer_q == DEB_LAST) begin
          state_d = ST_HELD;
          step_d  = 1'b1;
        end
      end
      ST_HELD: begin
        if (!btn_sync) begin
          state_d = ST_RELEASE;
        end else if (repeat_en && (timer_q == RD_LAST)) begin
          state_d = ST_REPEAT;
          step_d  = 1'b1;
        end
      end
      ST_REPEAT: begin
        // Release outranks repeat_en, which outranks the period tick.
        if (!btn_sync) begin
          state_d = ST_RELEASE;
        end else if (!repeat_en) begin
          state_d = ST_HELD;
        end else if (timer_q == RP_LAST) begin
          step_d  = 1'b1;
          timer_d = '0;
        end
      end
      ST_RELEASE: begin
        if (btn_sync) begin
          timer_d = '0;
        end else if (timer_q == DEB_LAST) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q) timer_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      step_q  <= step_d;
    end
  end

  assign step      = step_q;
  assign btn_level = state_is_pressed(state_q);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_button_step_controller.sv
// Randomised and directed bench for button_step_controller against a behavioural model.
module tb_button_step_controller;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_raw = 1'b0;
  logic       repeat_en = 1'b0;
  logic       step;
  logic       btn_level;
  logic [2:0] state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  int ctr     = 0;
  logic prev_step = 1'b0;

  // Model: pipeline of raw samples, spec state code, dwell count, expected step.
  int m_s1, m_s2, m_mode, m_cnt, m_step;

  always #5 clk = ~clk;

  button_step_controller dut (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .repeat_en (repeat_en),
    .step      (step),
    .btn_level (btn_level),
    .state_dbg (state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_mode = 0; m_cnt = 0; m_step = 0;
  endtask

  // One clock edge of the spec rules: 0 IDLE, 1 ARM, 2 HELD, 3 REPEAT, 4 RELEASE.
  task automatic model_edge();
    int pressed, nxt, restart;
    pressed = m_s2;
    m_s2 = m_s1;
    m_s1 = int'(btn_raw);
    m_step = 0;
    nxt = m_mode;
    restart = 0;
    case (m_mode)
      0: if (pressed == 1) nxt = 1;
      1: if (pressed == 0) nxt = 0;
         else if (m_cnt == D - 1) begin nxt = 2; m_step = 1; end
      2: if (pressed == 0) nxt = 4;
         else if (repeat_en && m_cnt == RD - 1) begin nxt = 3; m_step = 1; end
      3: if (pressed == 0) nxt = 4;
         else if (!repeat_en) nxt = 2;
         else if (m_cnt == RP - 1) begin m_step = 1; restart = 1; end
      4: if (pressed == 1) restart = 1;
         else if (m_cnt == D - 1) nxt = 0;
      default: nxt = 0;
    endcase
    m_cnt  = (nxt != m_mode || restart == 1) ? 0 : (m_cnt + 1) % 256;
    m_mode = nxt;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("step", step, m_step);
    chk("btn_level", btn_level, (m_mode >= 2 && m_mode <= 4) ? 1 : 0);
    chk("state_dbg", state_dbg, m_mode);
    chk("no_double_step", step & prev_step, 0);
    prev_step = step;
    if (step) ctr++;
  endtask

  // Called right after cycle(): asserts reset between edges and checks the immediate drop.
  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_step", step, 0);
    chk("rst_level", btn_level, 0);
    chk("rst_state", state_dbg, 0);
    model_reset();
    prev_step = 1'b0;
    #2 reset = 1'b0;
  endtask

  task automatic drive(input logic lvl, input int n);
    btn_raw = lvl;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int first, found, len;
    logic lvl;
    model_reset();
    #1 reset = 1'b1;
    #1;
    chk("init_step", step, 0);
    chk("init_level", btn_level, 0);
    chk("init_state", state_dbg, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Clean press, latency measured from the first edge that samples the press.
    ctr = 0; first = -1; btn_raw = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (step && first < 0) first = i;
    end
    chk("s1_latency", first, 6);
    drive(1'b0, 10);
    chk("s1_count", ctr, 1);
    chk("s1_idle", state_dbg, 0);

    // Bounce during ARM.
    ctr = 0;
    drive(1'b1, 2); drive(1'b0, 1); drive(1'b1, 12); drive(1'b0, 10);
    chk("s2_count", ctr, 1);

    // Auto-repeat hold.
    ctr = 0; repeat_en = 1'b1;
    drive(1'b1, 30); drive(1'b0, 10);
    chk("s3_count", ctr, 7);
    repeat_en = 1'b0;

    // Release bounce restarts the release debounce.
    ctr = 0;
    drive(1'b1, 10); drive(1'b0, 2); drive(1'b1, 1); drive(1'b0, 5);
    chk("s4_still_release", state_dbg, 4);
    drive(1'b0, 6);
    chk("s4_count", ctr, 1);
    chk("s4_idle", state_dbg, 0);

    // Reset while a repeat step is high.
    repeat_en = 1'b1; btn_raw = 1'b1; found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      cycle();
      if (step && state_dbg == 3'd3) found = 1;
    end
    chk("s5_found_repeat", found, 1);
    async_reset();
    repeat_en = 1'b0; first = -1;
    for (int i = 0; i < 20 && first < 0; i++) begin
      cycle();
      if (step) first = i;
    end
    chk("s5_relatency", first, 6);
    drive(1'b0, 12);

    // repeat_en dropped one cycle ahead of a period tick.
    repeat_en = 1'b1; btn_raw = 1'b1; found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      cycle();
      if (step && state_dbg == 3'd3) found = 1;
    end
    chk("s6_found_repeat", found, 1);
    cycle(); cycle();
    repeat_en = 1'b0;
    cycle();
    chk("s6_held", state_dbg, 2);
    chk("s6_no_step", step, 0);
    repeat_en = 1'b1; first = -1;
    for (int i = 1; i <= 20 && first < 0; i++) begin
      cycle();
      if (step) first = i;
    end
    chk("s6_rearm_delay", first, 10);
    repeat_en = 1'b0;
    drive(1'b0, 20);

    // Random segments with short bounces, long holds, repeat toggles and stray resets.
    for (int seg = 0; seg < 70; seg++) begin
      lvl = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : $urandom_range(4, 35);
      if ($urandom_range(0, 3) == 0) repeat_en = ~repeat_en;
      btn_raw = lvl;
      for (int i = 0; i < len; i++) begin
        cycle();
        if ($urandom_range(0, 150) == 0) async_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
